instr_mem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The CPU fetches 32-bit instructions from instruction memory using byte addresses that advance by 4.
- This block fills that memory before execution starts. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives a one-word write port into instruction memory.
- It sits beside the CPU top level. busy holds the PC/fetch path in stall while the program loads.

---
 rtl/instr_mem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: fills instruction memory from a byte stream before the CPU runs.
// The stream is a big-endian 16-bit word count followed by big-endian 32-bit words.
// Each assembled word gets one write cycle. busy stalls CPU fetch while a session runs.
module instr_mem_loader #(
    parameter  int unsigned MAX_WORDS = 256,
    parameter  int unsigned ADDR_STEP = 4,
    localparam int unsigned ADDR_W    = 32,
    localparam int unsigned DATA_W    = 32,
    localparam int unsigned BYTE_W    = 8,
    localparam int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned SHIFT_W = DATA_W - BYTE_W;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]   len_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [SHIFT_W-1:0] shift_q;

    logic               accept_c;
    logic               start_ok_c;
    logic               last_byte_c;
    logic               last_word_c;
    logic [CNT_W-1:0]   len_c;

    logic               in_ready_d;
    logic               busy_d;
    logic               done_d;
    logic               error_d;
    logic               mem_we_d;

    // Handshake and session-control decodes
    assign accept_c    = in_valid & in_ready;
    assign start_ok_c  = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
    assign last_byte_c = (byte_idx_q == IDX_W'(3));
    assign last_word_c = (CNT_W'(word_count + CNT_W'(1)) == len_q);
    assign len_c       = {len_q[CNT_W-1:BYTE_W], in_data};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept_c) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept_c) begin
                    if (len_c == '0) begin
                        state_d = DONE;
                    end else if (len_c > CNT_W'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept_c && last_byte_c) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = last_word_c ? DONE : DATA;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        mem_we_d   = 1'b0;
        case (state_d)
            LEN_HI, LEN_LO, DATA: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            WRITE: begin
                busy_d   = 1'b1;
                mem_we_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            ERR: begin
                error_d = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    // Control output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            mem_we   <= 1'b0;
        end else begin
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            mem_we   <= mem_we_d;
        end
    end

    // Length capture, word assembly, write address/data and word counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            if (start_ok_c) begin
                addr_q     <= base_addr;
                word_count <= '0;
                byte_idx_q <= '0;
            end
            if (accept_c) begin
                case (state_q)
                    LEN_HI: begin
                        len_q[CNT_W-1:BYTE_W] <= in_data;
                    end
                    LEN_LO: begin
                        len_q[BYTE_W-1:0] <= in_data;
                    end
                    DATA: begin
                        shift_q    <= {shift_q[SHIFT_W-BYTE_W-1:0], in_data};
                        byte_idx_q <= IDX_W'(byte_idx_q + IDX_W'(1));
                        // Fourth byte completes the word; present it on the write port
                        if (last_byte_c) begin
                            mem_addr  <= addr_q;
                            mem_wdata <= {shift_q, in_data};
                        end
                    end
                    default: begin
                        len_q <= len_q;
                    end
                endcase
            end
            // Word written this cycle: advance count and address (address wraps mod 2^32)
            if (state_q == WRITE) begin
                word_count <= CNT_W'(word_count + CNT_W'(1));
                addr_q     <= ADDR_W'(addr_q + ADDR_W'(ADDR_STEP));
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized load sessions checked against a
// word-list model (expected write i = base + 4*i with word i).
module tb_instr_mem_loader;

    localparam int unsigned MAX_WORDS = 256;
    localparam int unsigned ADDR_STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf [0:MAX_WORDS-1];
    logic [31:0] got_addr [$];
    logic [31:0] got_data [$];

    instr_mem_loader #(
        .MAX_WORDS (MAX_WORDS),
        .ADDR_STEP (ADDR_STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture every memory write; the loader must never offer ready during a write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            chk("ready_in_write", 32'(in_ready), 32'd0);
        end
    end

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = $urandom;
    endtask

    task automatic pulse_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        if (stall && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait_bound", 32'(n < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (24 - 8 * k)), stall);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("end_wait_bound", 32'(n < 20), 32'd1);
    endtask

    // Full session: start, length, words from wbuf; optional ignored start at word 'poke'
    task automatic load(input logic [31:0] base, input int n, input bit stall, input int poke);
        logic [15:0] len;
        len = 16'(n);
        clear_log();
        pulse_start(base);
        send_byte(len[15:8], stall);
        send_byte(len[7:0], stall);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                if (i == poke) pulse_start(~base);
                send_word(wbuf[i], stall);
            end
        end
        wait_end();
    endtask

    task automatic check_writes(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            chk({tag, "_addr"}, got_addr[i], base + 32'(i) * 32'(ADDR_STEP));
            chk({tag, "_data"}, got_data[i], wbuf[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed two-word program, no stalls, cycle-exact write and done timing
        wbuf[0] = 32'h012A_4020;
        wbuf[1] = 32'h0085_3022;
        clear_log();
        pulse_start(32'h0000_0000);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(wbuf[0], 1'b0);
        chk("t1_we0", 32'(mem_we), 32'd1);
        chk("t1_addr0", mem_addr, 32'h0000_0000);
        chk("t1_data0", mem_wdata, 32'h012A_4020);
        send_word(wbuf[1], 1'b0);
        chk("t1_we1", 32'(mem_we), 32'd1);
        chk("t1_addr1", mem_addr, 32'h0000_0004);
        chk("t1_data1", mem_wdata, 32'h0085_3022);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_wc", 32'(word_count), 32'd2);
        chk("t1_hold_addr", mem_addr, 32'h0000_0004);
        check_writes("t1", 32'h0000_0000, 2);

        // Same program with random source stalls
        load(32'h0000_0000, 2, 1'b1, -1);
        check_writes("t2", 32'h0000_0000, 2);
        chk("t2_done", 32'(done), 32'd1);

        // Zero-length program
        clear_log();
        pulse_start(32'h0000_0100);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_wc", 32'(word_count), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_nwrites", 32'(got_addr.size()), 32'd0);

        // Over-long program is rejected; error is sticky until the next start
        load(32'h0000_1000, MAX_WORDS + 1, 1'b0, -1);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_ready", 32'(in_ready), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_sticky", 32'(error), 32'd1);
        chk("t4_nwrites", 32'(got_addr.size()), 32'd0);
        fill_words(1);
        clear_log();
        pulse_start(32'h0000_2000);
        chk("t4_err_clr", 32'(error), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(wbuf[0], 1'b0);
        wait_end();
        check_writes("t4_recover", 32'h0000_2000, 1);
        chk("t4_recover_done", 32'(done), 32'd1);

        // Address wraps past the top of the 32-bit space
        fill_words(2);
        load(32'hFFFF_FFFC, 2, 1'b0, -1);
        check_writes("t5", 32'hFFFF_FFFC, 2);

        // Asynchronous reset in the middle of the second word of a 3-word load
        fill_words(3);
        clear_log();
        pulse_start(32'h0000_0300);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_word(wbuf[0], 1'b0);
        send_byte(8'(wbuf[1] >> 24), 1'b0);
        send_byte(8'(wbuf[1] >> 16), 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_nwrites", 32'(got_addr.size()), 32'd1);
        load(32'h0000_0500, 3, 1'b1, -1);
        check_writes("t6_fresh", 32'h0000_0500, 3);

        // Start pulses while busy are ignored
        fill_words(3);
        load(32'h0000_4000, 3, 1'b1, 1);
        check_writes("t7", 32'h0000_4000, 3);
        chk("t7_wc", 32'(word_count), 32'd3);

        // Randomized sessions
        for (int r = 0; r < 6; r++) begin
            int n;
            logic [31:0] b;
            n = $urandom_range(1, 8);
            b = {$urandom, 2'b00} ;
            fill_words(n);
            load(b, n, 1'b1, -1);
            check_writes("rand", b, n);
            chk("rand_wc", 32'(word_count), 32'(n));
            chk("rand_done", 32'(done), 32'd1);
        end

        // Largest accepted program
        fill_words(MAX_WORDS);
        load(32'h0000_8000, MAX_WORDS, 1'b0, -1);
        check_writes("max", 32'h0000_8000, MAX_WORDS);
        chk("max_done", 32'(done), 32'd1);
        chk("max_error", 32'(error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
